// File: rtl/man_pkg.sv
// Shared Manchester frame geometry and decoder state encoding.
// Also used by the matching encoder.
package man_pkg;

    localparam int DATA_CAPACITY = 8;
    localparam int BIT_LENGTH    = 10;
    localparam int PREAMBLE_LEN  = 2;
    localparam int CNT_W         = 32;
    localparam int BCNT_W        = 4;

    typedef enum logic {
        HUNT = 1'b0,
        BIT  = 1'b1
    } man_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/man_edge_det.sv
// Input synchronizer and rise/fall detector for the Manchester line.
// MAN_DECODER_SYNC_EN selects a 2-flop synchronizer instead of 1 flop.
module man_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

`ifdef MAN_DECODER_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], din};
        end
    end

    assign level = sync[1];
`else
    logic sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 1'b0;
        end else begin
            sync <= din;
        end
    end

    assign level = sync;
`endif

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/man_decoder.sv
// Manchester frame decoder: 2 preamble zeros then 8 data bits, MSB first.
// Build option MAN_DECODER_SYNC_EN deepens the input synchronizer.
module man_decoder
    import man_pkg::*;
(
    input  logic                     _clk,
    input  logic                     _rst_n,
    input  logic                     _input_wire,
    input  logic [31:0]              _divide_freq,
    output logic [DATA_CAPACITY-1:0] _output_reg,
    output logic                     _valid,
    output logic                     _err,
    output logic                     _busy
);

    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(BIT_LENGTH - 1);
    localparam logic [BCNT_W-1:0] PRE_END  = BCNT_W'(PREAMBLE_LEN);

    logic rise;
    logic fall;
    logic level;

    man_edge_det u_edge (
        .clk   (_clk),
        .rst_n (_rst_n),
        .din   (_input_wire),
        .rise  (rise),
        .fall  (fall),
        .level (level)
    );

    man_state_t               state;
    logic [CNT_W-1:0]         h_m1;
    logic [CNT_W-1:0]         cnt;
    logic [BCNT_W-1:0]        bit_cnt;
    logic [DATA_CAPACITY-1:0] shift;

    logic [CNT_W-1:0] elapsed;
    logic [CNT_W+1:0] h_full;
    logic [CNT_W+1:0] win_lo;
    logic [CNT_W+1:0] win_hi_m1;
    logic [CNT_W+1:0] elapsed_x;
    logic             in_window;
    logic             timeout;
    logic             new_bit;

    // elapsed = clocks since the detect cycle of the last mid-bit edge
    assign elapsed   = sat_inc(cnt);
    assign elapsed_x = {2'b00, elapsed};
    assign h_full    = {2'b00, h_m1} + 34'd1;
    assign win_lo    = h_full + (h_full >> 1);
    assign win_hi_m1 = win_lo + h_full - 34'd1;
    assign in_window = (rise | fall) && (elapsed_x >= win_lo);
    // Registered err lands in the cycle the count reaches 2H+H/2
    assign timeout   = elapsed_x >= win_hi_m1;
    assign new_bit   = ~level;

    always_ff @(posedge _clk) begin
        if (!_rst_n) begin
            state       <= HUNT;
            h_m1        <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            _output_reg <= '0;
            _valid      <= 1'b0;
            _err        <= 1'b0;
            _busy       <= 1'b0;
        end else begin
            _valid <= 1'b0;
            _err   <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (rise) begin
                        h_m1    <= _divide_freq;
                        shift   <= '0;
                        bit_cnt <= BCNT_W'(1);
                        cnt     <= '0;
                        state   <= BIT;
                        _busy   <= 1'b1;
                    end
                end
                BIT: begin
                    if (in_window) begin
                        cnt <= '0;
                        if (bit_cnt < PRE_END && new_bit) begin
                            _err  <= 1'b1;
                            state <= HUNT;
                            _busy <= 1'b0;
                        end else if (bit_cnt == LAST_BIT) begin
                            _output_reg <= {shift[DATA_CAPACITY-2:0],
                                            new_bit};
                            _valid      <= 1'b1;
                            state       <= HUNT;
                            _busy       <= 1'b0;
                        end else begin
                            shift   <= {shift[DATA_CAPACITY-2:0], new_bit};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (timeout) begin
                        cnt   <= '0;
                        _err  <= 1'b1;
                        state <= HUNT;
                        _busy <= 1'b0;
                    end else begin
                        cnt <= elapsed;
                    end
                end
                default: begin
                    state <= HUNT;
                    _busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_man_decoder.sv
// Directed bench for man_decoder: encodes frames on the line and
// checks decoded bytes, pulse timing, errors and reset behaviour.
module tb_man_decoder;

`ifdef MAN_DECODER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        line;
    logic [31:0] div;
    logic [7:0]  out_byte;
    logic        valid;
    logic        err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mid_edge    = 0;
    int valid_cnt   = 0;
    int err_cnt     = 0;
    int valid_cyc   = -1;
    int err_cyc     = -1;
    int both_cnt    = 0;
    int long_cnt    = 0;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;
    logic [7:0] vals[$];

    man_decoder dut (
        ._clk         (clk),
        ._rst_n       (rst_n),
        ._input_wire  (line),
        ._divide_freq (div),
        ._output_reg  (out_byte),
        ._valid       (valid),
        ._err         (err),
        ._busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            vals.push_back(out_byte);
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (valid && err) both_cnt++;
        if ((valid && prev_valid) || (err && prev_err)) long_cnt++;
        prev_valid = valid;
        prev_err   = err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int h);
        line = lvl;
        repeat (h) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] bits, input int h,
                             input int nbits, input int glitch);
        for (int i = 0; i < nbits; i++) begin
            hold(bits[9-i], h);
            mid_edge = cyc;
            if (i == glitch) begin
                hold(!bits[9-i], 1);
                hold(bits[9-i], 1);
                hold(!bits[9-i], h - 2);
            end else begin
                hold(!bits[9-i], h);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int h,
                             input int glitch);
        send_bits({2'b00, d}, h, 10, glitch);
        line = 1'b0;
    endtask

    task automatic idle(input int n);
        line = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0;
    int e0;
    int n0;

    initial begin
        rst_n = 1'b0;
        line  = 1'b0;
        div   = 32'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", out_byte, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // Single frame A5 at H=4
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'hA5, 4, -1);
        idle(6);
        check("a5_nvalid", valid_cnt - v0, 1);
        check("a5_value", out_byte, 8'hA5);
        check("a5_noerr", err_cnt - e0, 0);
        check("a5_vtime", valid_cyc, mid_edge + LAT + 1);
        check("a5_busy", busy, 1'b0);

        // Back-to-back 00 then FF, 10-clock gap
        v0 = valid_cnt; n0 = vals.size();
        send_byte(8'h00, 4, -1);
        idle(10);
        send_byte(8'hFF, 4, -1);
        idle(6);
        check("b2b_nvalid", valid_cnt - v0, 2);
        check("b2b_first", (vals.size() > n0) ? vals[n0] : 8'hxx, 8'h00);
        check("b2b_second",
              (vals.size() > n0 + 1) ? vals[n0+1] : 8'hxx, 8'hFF);

        // Preamble violation: second bit is 1
        v0 = valid_cnt; e0 = err_cnt;
        send_bits(10'b01_0000_0000, 4, 2, -1);
        idle(20);
        check("pre_nerr", err_cnt - e0, 1);
        check("pre_etime", err_cyc, mid_edge + LAT + 1);
        check("pre_novalid", valid_cnt - v0, 0);
        check("pre_keep", out_byte, 8'hFF);

        // Line frozen after 5 bits, then a good 3C frame
        v0 = valid_cnt; e0 = err_cnt;
        send_bits({2'b00, 8'h3C}, 4, 5, -1);
        repeat (20) @(posedge clk);
        #1;
        check("frz_nerr", err_cnt - e0, 1);
        check("frz_etime", err_cyc, mid_edge + LAT + 10);
        check("frz_novalid", valid_cnt - v0, 0);
        send_byte(8'h3C, 4, -1);
        idle(6);
        check("frz_value", out_byte, 8'h3C);
        check("frz_nvalid", valid_cnt - v0, 1);

        // Reset for one cycle in the middle of a frame
        send_bits({2'b00, 8'h5A}, 4, 4, -1);
        @(negedge clk);
        check("mid_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        line  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        v0 = valid_cnt; e0 = err_cnt;
        @(negedge clk);
        check("mrst_out", out_byte, 8'h00);
        check("mrst_valid", valid, 1'b0);
        check("mrst_err", err, 1'b0);
        check("mrst_busy", busy, 1'b0);
        idle(30);
        check("mrst_novalid", valid_cnt - v0, 0);
        check("mrst_noerr", err_cnt - e0, 0);
        send_byte(8'h5A, 4, -1);
        idle(6);
        check("mrst_value", out_byte, 8'h5A);
        check("mrst_nvalid", valid_cnt - v0, 1);

        // One-clock glitch inside the blanking window
        v0 = valid_cnt; e0 = err_cnt;
        send_byte(8'hC3, 4, 3);
        idle(6);
        check("glt_value", out_byte, 8'hC3);
        check("glt_nvalid", valid_cnt - v0, 1);
        check("glt_noerr", err_cnt - e0, 0);

        // H=6, divider rewritten mid-frame must not matter
        div = 32'd5;
        v0 = valid_cnt; e0 = err_cnt;
        fork
            send_byte(8'h96, 6, -1);
            begin
                repeat (20) @(posedge clk);
                #2 div = 32'd3;
            end
        join
        idle(8);
        check("h6_value", out_byte, 8'h96);
        check("h6_nvalid", valid_cnt - v0, 1);
        check("h6_noerr", err_cnt - e0, 0);

        check("never_both", both_cnt, 0);
        check("one_cycle", long_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/man_decoder.md
MAN_DECODER -- requirements
Module: man_decoder

Interface
REQ-001 SHALL have parameters: none; frame geometry comes from man_pkg constants DATA_CAPACITY=8, BIT_LENGTH=10, PREAMBLE_LEN=2.
REQ-002 SHALL have ports: _clk  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: _rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: _input_wire  in  1  Manchester line: bit 1 = high-then-low, bit 0 = low-then-high, MSB first.
REQ-005 SHALL have ports: _divide_freq  in  32  half-bit period H = _divide_freq+1 clocks.
REQ-006 SHALL have ports: _output_reg  out  8  last good data byte.
REQ-007 SHALL have ports: _valid  out  1  one-cycle pulse, new byte on _output_reg.
REQ-008 SHALL have ports: _err  out  1  one-cycle pulse, frame aborted.
REQ-009 SHALL have ports: _busy  out  1  high while a frame is being received.

Function
REQ-010 SHALL accept frames of BIT_LENGTH bits: 2 preamble zeros, then 8 data bits MSB first.
REQ-011 SHALL detect line edges on the synchronized input (sync depth per REQ-024); "edge" below means a level change seen there.
REQ-012 SHALL run states HUNT, BIT; HUNT is the reset state.
REQ-013 HUNT: ignore falling edges; on a rising edge latch _divide_freq as H-1, record bit 0, set bit count 1, clear counter, go to BIT, assert _busy.
REQ-014 BIT: counter increments each clock from the last mid-bit edge; edges while counter < H+H/2 (blanking, bit-boundary transitions) SHALL be ignored.
REQ-015 BIT: first edge with H+H/2 <= counter < 2H+H/2 is a mid-bit edge: rising gives 0, falling gives 1; shift bit in, increment bit count, clear counter.
REQ-016 BIT: counter reaching 2H+H/2 with no mid-bit edge SHALL pulse _err, go to HUNT, leave _output_reg unchanged.
REQ-017 Second decoded bit not 0 (preamble violation) SHALL pulse _err, go to HUNT.
REQ-018 On the 10th mid-bit edge: next cycle load _output_reg with the 8 data bits, pulse _valid, go to HUNT, drop _busy.
REQ-019 _valid and _err SHALL never be high in the same cycle; each pulse is exactly one cycle.
REQ-020 Counter SHALL be 32 bits and saturate, no wrap; H/2 SHALL be floor(H/2).
REQ-021 _divide_freq changes mid-frame SHALL have no effect until the next HUNT start.
REQ-022 _divide_freq < 3 is unsupported; decoded values are then undefined but the FSM SHALL still return to HUNT.

Reset
REQ-023 _rst_n low at a rising _clk: state HUNT, counters and shift register 0, _output_reg 8'h00, _valid/_err/_busy 0, synchronizer flops 0, whether idle or mid-frame; no _valid or _err from an aborted frame.

Configuration
REQ-024 Macro MAN_DECODER_SYNC_EN: defined gives a 2-flop synchronizer before edge detect (input latency 2 cycles); undefined gives 1 flop (latency 1); decode rules are otherwise identical.

Structure
REQ-025 man_pkg SHALL hold DATA_CAPACITY, BIT_LENGTH, PREAMBLE_LEN and the state encoding, shared with the encoder.
REQ-026 Synchronizer plus rise/fall detect SHALL be sub-module man_edge_det (outputs rise, fall, level).

Verification
REQ-027 _divide_freq=3 (H=4), encoder sends 8'hA5 -> one _valid, _output_reg=8'hA5, _err never high.
REQ-028 Back-to-back 8'h00 then 8'hFF with a 10-clock gap, H=4 -> two _valid pulses, values 8'h00 then 8'hFF.
REQ-029 Frame whose second bit is 1 -> _err pulse one cycle after that falling mid-bit edge, no _valid, _output_reg keeps its prior value.
REQ-030 Line frozen after 5 bits, H=4 -> _err exactly 10 clocks (plus sync latency) after the last mid-bit edge, then a correct 8'h3C frame decodes.
REQ-031 _rst_n low for 1 cycle mid-frame -> all outputs 0 next cycle, no _valid for that frame, next full frame 8'h5A decodes.
REQ-032 Glitch pulse of 1 clock inside the blanking window -> ignored, byte still correct; with and without MAN_DECODER_SYNC_EN.
